// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module      : mem_stage
// Description : RV32I memory-access stage. Issues loads/stores on a req/gnt/
//               rvalid data bus and emits one registered writeback record per
//               accepted instruction.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_wr_reg_en,
  input  logic [4:0]        ex_wr_reg_addr,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_inst,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_wr_reg_en,
  output logic [4:0]        wb_wr_reg_addr,
  output logic [31:0]       wb_wdata,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_inst,
  output logic              misalign_o
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Instruction context captured on accept, used when the bus op completes
  logic [31:0] r_result;
  logic        r_wr_reg_en;
  logic [4:0]  r_rd;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [2:0]  r_funct3;
  logic [1:0]  r_k;

  // Decode of the incoming instruction
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_load_ok;
  logic        w_store_ok;
  logic        w_misal;
  logic        w_fault;
  logic        w_mem;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  // Writeback selection
  logic        w_wb_fire;
  logic        w_wb_use_ex;
  logic        w_wb_en;
  logic        w_wb_fault;
  logic [31:0] w_wb_data;

  assign w_funct3   = ex_inst[14:12];
  assign w_is_load  = (ex_inst[6:0] == c_op_load);
  assign w_is_store = (ex_inst[6:0] == c_op_store);
  assign w_load_ok  = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
  assign w_store_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
  assign w_misal    = ((w_funct3[1:0] == 2'b01) && ex_result[0]) ||
                      ((w_funct3[1:0] == 2'b10) && (ex_result[1:0] != 2'b00));
  assign w_fault    = (w_is_load  && (!w_load_ok  || w_misal)) ||
                      (w_is_store && (!w_store_ok || w_misal));
  assign w_mem      = (w_is_load || w_is_store) && !w_fault;
  assign ex_ready   = (r_state == ST_IDLE);
  assign w_accept   = ex_valid && ex_ready;

  always_comb begin
    w_be         = 4'b1111;
    w_lane_wdata = ex_store_data;
    case (w_funct3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << ex_result[1:0];
        w_lane_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        w_be         = ex_result[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        w_be         = 4'b1111;
        w_lane_wdata = ex_store_data;
      end
    endcase
  end

  assign w_shifted = dmem_rdata >> {r_k, 3'b000};

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_wb_fire    = 1'b0;
    w_wb_use_ex  = 1'b0;
    w_wb_en      = 1'b0;
    w_wb_fault   = 1'b0;
    w_wb_data    = r_result;
    case (r_state)
      ST_IDLE: begin
        if (ex_valid) begin
          if (w_mem) begin
            w_state_next = ST_REQ;
          end else begin
            w_wb_fire   = 1'b1;
            w_wb_use_ex = 1'b1;
            w_wb_fault  = w_fault;
            w_wb_en     = ex_wr_reg_en && !w_fault;
            w_wb_data   = ex_result;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (dmem_we) begin
            w_state_next = ST_IDLE;
            w_wb_fire    = 1'b1;
          end else begin
            w_state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          w_state_next = ST_IDLE;
          w_wb_fire    = 1'b1;
          w_wb_en      = r_wr_reg_en;
          w_wb_data    = w_load_data;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= 32'h0;
      dmem_be        <= 4'b0000;
      wb_valid       <= 1'b0;
      wb_wr_reg_en   <= 1'b0;
      wb_wr_reg_addr <= 5'd0;
      wb_wdata       <= 32'h0;
      wb_pc          <= RESET_PC;
      wb_inst        <= 32'h0;
      misalign_o     <= 1'b0;
      r_result       <= 32'h0;
      r_wr_reg_en    <= 1'b0;
      r_rd           <= 5'd0;
      r_pc           <= 32'h0;
      r_inst         <= 32'h0;
      r_funct3       <= 3'b000;
      r_k            <= 2'b00;
    end else begin
      wb_valid   <= w_wb_fire;
      misalign_o <= w_wb_fire && w_wb_fault;

      if (w_wb_fire) begin
        wb_wr_reg_en   <= w_wb_en;
        wb_wdata       <= w_wb_data;
        wb_wr_reg_addr <= w_wb_use_ex ? ex_wr_reg_addr : r_rd;
        wb_pc          <= w_wb_use_ex ? ex_pc : r_pc;
        wb_inst        <= w_wb_use_ex ? ex_inst : r_inst;
      end

      if (w_accept) begin
        r_result    <= ex_result;
        r_wr_reg_en <= ex_wr_reg_en;
        r_rd        <= ex_wr_reg_addr;
        r_pc        <= ex_pc;
        r_inst      <= ex_inst;
        r_funct3    <= w_funct3;
        r_k         <= ex_result[1:0];
      end

      // Bus fields stay frozen from accept through the grant cycle
      if (w_accept && w_mem) begin
        dmem_req   <= 1'b1;
        dmem_we    <= w_is_store;
        dmem_addr  <= {ex_result[ADDR_W-1:2], 2'b00};
        dmem_wdata <= w_lane_wdata;
        dmem_be    <= w_is_store ? w_be : 4'b0000;
      end else if ((r_state == ST_REQ) && dmem_gnt) begin
        dmem_req <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage; expected writeback records are
//               queued at issue and compared when wb_valid pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  localparam logic [31:0] c_reset_pc = 32'h0000_1000;
  localparam logic [6:0]  c_op_load  = 7'b0000011;
  localparam logic [6:0]  c_op_store = 7'b0100011;
  localparam logic [6:0]  c_op_imm   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic        ex_wr_reg_en;
  logic [4:0]  ex_wr_reg_addr;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_wr_reg_en;
  logic [4:0]  wb_wr_reg_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        misalign_o;

  mem_stage #(.ADDR_W(32), .RESET_PC(c_reset_pc)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_wr_reg_en(ex_wr_reg_en),
    .ex_wr_reg_addr(ex_wr_reg_addr), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_wr_reg_en(wb_wr_reg_en),
    .wb_wr_reg_addr(wb_wr_reg_addr), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .wb_inst(wb_inst), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        cmp_data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } wb_exp_t;

  wb_exp_t q_exp[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] r_next_pc = 32'h0000_0100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  // Scoreboard consumer: every writeback pulse must match the oldest expectation
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (q_exp.size() == 0) begin
        chk("unexpected_wb", 32'd1, 32'd0);
      end else begin
        wb_exp_t e;
        e = q_exp.pop_front();
        chk("wb_wr_reg_en", {31'h0, wb_wr_reg_en}, {31'h0, e.en});
        chk("wb_misalign", {31'h0, misalign_o}, {31'h0, e.mis});
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_inst", wb_inst, e.inst);
        if (e.en) chk("wb_wr_reg_addr", {27'h0, wb_wr_reg_addr}, {27'h0, e.rd});
        if (e.cmp_data) chk("wb_wdata", wb_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic en, input logic [4:0] rd, input logic [31:0] data,
                          input logic cmp, input logic [31:0] inst, input logic mis);
    wb_exp_t e;
    e.en = en; e.rd = rd; e.data = data; e.cmp_data = cmp;
    e.pc = r_next_pc; e.inst = inst; e.mis = mis;
    q_exp.push_back(e);
  endtask

  // Presents one instruction for exactly one accepting edge
  task automatic issue(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input logic en);
    ex_valid = 1'b1; ex_inst = inst; ex_result = res; ex_store_data = sd;
    ex_wr_reg_addr = rd; ex_wr_reg_en = en; ex_pc = r_next_pc;
    chk("ex_ready_at_issue", {31'h0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0;
    r_next_pc = r_next_pc + 32'd4;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                          input int gnt_wait, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_addr);
    logic [31:0] inst;
    inst = mk_inst(c_op_store, f3, 5'd0);
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, inst, 1'b0);
    issue(inst, a, rs2, 5'd0, 1'b0);
    for (int i = 0; i <= gnt_wait; i++) begin
      if (i == gnt_wait) dmem_gnt = 1'b1;
      chk("st_req", {31'h0, dmem_req}, 32'd1);
      chk("st_we", {31'h0, dmem_we}, 32'd1);
      chk("st_be", {28'h0, dmem_be}, {28'h0, exp_be});
      chk("st_addr", dmem_addr, exp_addr);
      chk("st_wdata", dmem_wdata, exp_wd);
      chk("st_ex_ready", {31'h0, ex_ready}, 32'd0);
      tick();
    end
    dmem_gnt = 1'b0;
    chk("st_wb_latency", {31'h0, wb_valid}, 32'd1);
    chk("st_req_drop", {31'h0, dmem_req}, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic [31:0] exp_addr);
    logic [31:0] inst;
    inst = mk_inst(c_op_load, f3, rd);
    push_exp(1'b1, rd, exp_data, 1'b1, inst, 1'b0);
    issue(inst, a, 32'h0, rd, 1'b1);
    for (int i = 0; i <= gnt_wait; i++) begin
      if (i == gnt_wait) dmem_gnt = 1'b1;
      chk("ld_req", {31'h0, dmem_req}, 32'd1);
      chk("ld_we", {31'h0, dmem_we}, 32'd0);
      chk("ld_be", {28'h0, dmem_be}, 32'd0);
      chk("ld_addr", dmem_addr, exp_addr);
      tick();
    end
    dmem_gnt = 1'b0;
    chk("ld_req_drop", {31'h0, dmem_req}, 32'd0);
    for (int i = 1; i < rv_wait; i++) begin
      chk("ld_wb_early", {31'h0, wb_valid}, 32'd0);
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_0000;
    chk("ld_wb_latency", {31'h0, wb_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] inst;
    rst_n = 1'b0; ex_valid = 1'b0; ex_result = 32'h0; ex_store_data = 32'h0;
    ex_wr_reg_en = 1'b0; ex_wr_reg_addr = 5'd0; ex_pc = 32'h0; ex_inst = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();

    chk("rst_dmem_req", {31'h0, dmem_req}, 32'd0);
    chk("rst_dmem_be", {28'h0, dmem_be}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    chk("rst_wb_pc", wb_pc, c_reset_pc);
    chk("rst_wb_inst", wb_inst, 32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'd0);
    chk("rst_ex_ready", {31'h0, ex_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Pass-through ORI, single then three back-to-back
    inst = {12'h0F5, 5'd0, 3'b110, 5'd5, c_op_imm};
    push_exp(1'b1, 5'd5, 32'h0000_00F5, 1'b1, inst, 1'b0);
    issue(inst, 32'h0000_00F5, 32'h0, 5'd5, 1'b1);
    chk("pt_latency", {31'h0, wb_valid}, 32'd1);
    chk("pt_no_req", {31'h0, dmem_req}, 32'd0);
    tick();
    chk("pt_single_pulse", {31'h0, wb_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      inst = mk_inst(c_op_imm, 3'b000, 5'(i + 1));
      push_exp(1'b1, 5'(i + 1), 32'h1111_0000 + 32'(i), 1'b1, inst, 1'b0);
      issue(inst, 32'h1111_0000 + 32'(i), 32'h0, 5'(i + 1), 1'b1);
      chk("b2b_wb_pulse", {31'h0, wb_valid}, 32'd1);
    end
    tick();
    chk("b2b_wb_end", {31'h0, wb_valid}, 32'd0);

    // Stores
    do_store(3'b000, 32'h0000_0101, 32'h0000_00AB, 2, 4'b0010, 32'hABAB_ABAB, 32'h0000_0100);
    do_store(3'b001, 32'h0000_0302, 32'h1234_5678, 0, 4'b1100, 32'h5678_5678, 32'h0000_0300);
    do_store(3'b010, 32'h0000_0304, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0304);

    // Loads
    do_load(3'b000, 32'h0000_0203, 1, 2, 32'h8012_3456, 5'd7, 32'hFFFF_FF80, 32'h0000_0200);
    do_load(3'b100, 32'h0000_0203, 0, 2, 32'h8012_3456, 5'd8, 32'h0000_0080, 32'h0000_0200);
    do_load(3'b101, 32'h0000_0202, 0, 1, 32'h9234_5678, 5'd9, 32'h0000_9234, 32'h0000_0200);
    do_load(3'b001, 32'h0000_0202, 2, 1, 32'h9234_5678, 5'd10, 32'hFFFF_9234, 32'h0000_0200);
    do_load(3'b000, 32'h0000_0201, 0, 3, 32'h0000_7F00, 5'd11, 32'h0000_007F, 32'h0000_0200);
    do_load(3'b010, 32'h0000_0208, 0, 1, 32'hCAFE_F00D, 5'd12, 32'hCAFE_F00D, 32'h0000_0208);

    // Misaligned word load and illegal funct3 load fault in one cycle
    inst = mk_inst(c_op_load, 3'b010, 5'd13);
    push_exp(1'b0, 5'd13, 32'h0, 1'b0, inst, 1'b1);
    issue(inst, 32'h0000_0102, 32'h0, 5'd13, 1'b1);
    chk("mis_no_req", {31'h0, dmem_req}, 32'd0);
    chk("mis_wb_valid", {31'h0, wb_valid}, 32'd1);
    chk("mis_flag", {31'h0, misalign_o}, 32'd1);
    chk("mis_ex_ready", {31'h0, ex_ready}, 32'd1);
    inst = mk_inst(c_op_load, 3'b011, 5'd14);
    push_exp(1'b0, 5'd14, 32'h0, 1'b0, inst, 1'b1);
    issue(inst, 32'h0000_0100, 32'h0, 5'd14, 1'b1);
    chk("ill_no_req", {31'h0, dmem_req}, 32'd0);
    chk("ill_flag", {31'h0, misalign_o}, 32'd1);
    tick();
    chk("mis_flag_pulse", {31'h0, misalign_o}, 32'd0);

    // Reset while waiting for load data abandons the access
    inst = mk_inst(c_op_load, 3'b010, 5'd15);
    issue(inst, 32'h0000_0400, 32'h0, 5'd15, 1'b1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("resp_ex_ready", {31'h0, ex_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_req", {31'h0, dmem_req}, 32'd0);
    chk("rst_mid_wb", {31'h0, wb_valid}, 32'd0);
    chk("rst_mid_ready", {31'h0, ex_ready}, 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_rvalid_wb", {31'h0, wb_valid}, 32'd0);
    tick();
    chk("late_rvalid_wb2", {31'h0, wb_valid}, 32'd0);

    chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
